// File: rtl/cmd_conditioner.sv
// Filters raw classifier codes into confirmed one-hot game commands for vga_pic.
// Holds each command until it is consumed at frame start, with priority arbitration and a JUMP cooldown.
module cmd_conditioner #(
  parameter int STABLE_N    = 3,
  parameter int COOLDOWN_FR = 8
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       cls_valid,
  input  logic [3:0] cls_code,
  output logic [3:0] data_out,
  output logic       cmd_drop
);

  localparam logic [3:0] C_NONE    = 4'b0000;
  localparam logic [3:0] C_JUMP    = 4'b0001;
  localparam logic [3:0] C_LEFT    = 4'b0010;
  localparam logic [3:0] C_RESTART = 4'b0100;
  localparam logic [3:0] C_RIGHT   = 4'b1000;

  localparam int CW = (STABLE_N < 2) ? 1 : $clog2(STABLE_N);
  localparam int KW = (COOLDOWN_FR < 2) ? 1 : $clog2(COOLDOWN_FR + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_N - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'((STABLE_N > 1) ? 1 : 0);
  localparam logic [KW-1:0] COOL_LD = KW'(COOLDOWN_FR);

  logic [3:0]    last_code, last_code_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [KW-1:0] cool_cnt, cool_cnt_nxt;
  logic [3:0]    data_nxt;
  logic          drop_nxt;

  logic [3:0] code_n;
  logic       legal, same, confirm, accept, fs, jump_blk;

  function automatic logic [1:0] prio(input logic [3:0] c);
    case (c)
      C_RESTART:       prio = 2'd3;
      C_JUMP:          prio = 2'd2;
      C_LEFT, C_RIGHT: prio = 2'd1;
      default:         prio = 2'd0;
    endcase
  endfunction

  always_comb begin
    code_n = C_NONE;
    case (cls_code)
      C_JUMP, C_LEFT, C_RESTART, C_RIGHT: code_n = cls_code;
      default:                            code_n = C_NONE;
    endcase
  end

  // Illegal codes collapse to NONE, so a run of mixed illegal codes is one "same" stream that never confirms.
  assign legal    = (code_n != C_NONE);
  assign same     = (code_n == last_code);
  assign confirm  = cls_valid && legal && (same || (STABLE_N == 1)) && (cnt == CNT_MAX);
  assign fs       = (pix_x == 10'd0) && (pix_y == 10'd0);
  assign jump_blk = (cool_cnt != '0) || (fs && (data_out == C_JUMP));
  assign accept   = confirm && !((code_n == C_JUMP) && jump_blk);

  always_comb begin
    last_code_nxt = last_code;
    cnt_nxt       = cnt;
    if (cls_valid) begin
      if (!same) begin
        last_code_nxt = code_n;
        cnt_nxt       = CNT_ONE;
      end else if (confirm) begin
        cnt_nxt = '0;
      end else if (cnt != CNT_MAX) begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  always_comb begin
    data_nxt = data_out;
    drop_nxt = 1'b0;
    if (confirm && !accept)
      drop_nxt = 1'b1;
    if (fs) begin
      // vga_pic samples the current data_out at this edge, so it is consumed regardless.
      data_nxt = accept ? code_n : C_NONE;
    end else if (accept) begin
      if (data_out == C_NONE) begin
        data_nxt = code_n;
      end else begin
        drop_nxt = 1'b1;
        if (prio(code_n) >= prio(data_out))
          data_nxt = code_n;
      end
    end
  end

  always_comb begin
    cool_cnt_nxt = cool_cnt;
    if (confirm && (code_n == C_RESTART))
      cool_cnt_nxt = '0;
    else if (fs && (data_out == C_JUMP))
      cool_cnt_nxt = COOL_LD;
    else if (fs && (cool_cnt != '0))
      cool_cnt_nxt = cool_cnt - KW'(1);
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last_code <= C_NONE;
      cnt       <= '0;
      cool_cnt  <= '0;
      data_out  <= C_NONE;
      cmd_drop  <= 1'b0;
    end else begin
      last_code <= last_code_nxt;
      cnt       <= cnt_nxt;
      cool_cnt  <= cool_cnt_nxt;
      data_out  <= data_nxt;
      cmd_drop  <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_cmd_conditioner.sv
// Directed scenarios for cmd_conditioner; each driven cycle queues its expected outputs,
// which are popped and compared after the following clock edge.
module tb_cmd_conditioner;

  logic       vga_clk;
  logic       sys_rst_n;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       cls_valid;
  logic [3:0] cls_code;
  logic [3:0] data_out;
  logic       cmd_drop;

  int errors = 0;
  int checks = 0;
  logic [3:0] hold = 4'b0000;

  typedef struct {
    logic [3:0] d;
    logic       drop;
    string      tag;
  } exp_t;
  exp_t exp_q[$];

  cmd_conditioner #(.STABLE_N(3), .COOLDOWN_FR(8)) dut (
    .vga_clk  (vga_clk),
    .sys_rst_n(sys_rst_n),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .cls_valid(cls_valid),
    .cls_code (cls_code),
    .data_out (data_out),
    .cmd_drop (cmd_drop)
  );

  initial vga_clk = 1'b0;
  always #20 vga_clk = ~vga_clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, queue the expected post-edge outputs, then compare.
  task automatic cyc(input logic v, input logic [3:0] c, input logic f,
                     input logic [3:0] ed, input logic edr, input string tag);
    exp_t e;
    cls_valid = v;
    cls_code  = c;
    pix_x = f ? 10'd0 : (v ? 10'd0 : 10'd100);
    pix_y = f ? 10'd0 : (v ? 10'd7 : 10'd0);
    exp_q.push_back('{ed, edr, tag});
    @(posedge vga_clk);
    #1;
    e = exp_q.pop_front();
    check({e.tag, "_data"}, {4'b0, data_out}, {4'b0, e.d});
    check({e.tag, "_drop"}, {7'b0, cmd_drop}, {7'b0, e.drop});
    hold = ed;
  endtask

  // A valid sample every 4 clocks; idle cycles carry a decoy code with cls_valid low.
  task automatic smp(input logic [3:0] c, input logic [3:0] ed, input logic edr, input string tag);
    repeat (3) cyc(1'b0, 4'b0100, 1'b0, hold, 1'b0, {tag, "_idle"});
    cyc(1'b1, c, 1'b0, ed, edr, tag);
  endtask

  task automatic frm(input logic [3:0] ed, input string tag);
    cyc(1'b0, 4'b0100, 1'b1, ed, 1'b0, tag);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    cls_valid = 1'b0;
    cls_code  = 4'b0000;
    pix_x     = 10'd100;
    pix_y     = 10'd50;
    #3;
    check("rst_data", {4'b0, data_out}, 8'h00);
    check("rst_drop", {7'b0, cmd_drop}, 8'h00);
    repeat (2) @(posedge vga_clk);
    @(negedge vga_clk);
    sys_rst_n = 1'b1;

    // basic confirm, hold until frame start, then consumed (cooldown now 8)
    smp(4'b0001, 4'b0000, 1'b0, "t1_s1");
    smp(4'b0001, 4'b0000, 1'b0, "t1_s2");
    smp(4'b0001, 4'b0001, 1'b0, "t1_cfm");
    repeat (5) cyc(1'b0, 4'b0100, 1'b0, 4'b0001, 1'b0, "t1_hold");
    frm(4'b0000, "t1_fs");

    // counter restarts on a code change; eventual confirm lands in cooldown
    smp(4'b0001, 4'b0000, 1'b0, "t2_a");
    smp(4'b0001, 4'b0000, 1'b0, "t2_b");
    smp(4'b0010, 4'b0000, 1'b0, "t2_c");
    smp(4'b0001, 4'b0000, 1'b0, "t2_d");
    smp(4'b0001, 4'b0000, 1'b0, "t2_e");
    smp(4'b0001, 4'b0000, 1'b1, "t2_cfm_drop");

    // cooldown boundary: dropped before the 8th frame start, accepted after it
    for (int i = 0; i < 7; i++) frm(4'b0000, "t3_fr");
    smp(4'b0001, 4'b0000, 1'b0, "t3_e1");
    smp(4'b0001, 4'b0000, 1'b0, "t3_e2");
    smp(4'b0001, 4'b0000, 1'b1, "t3_early");
    frm(4'b0000, "t3_f8");
    smp(4'b0001, 4'b0000, 1'b0, "t3_a1");
    smp(4'b0001, 4'b0000, 1'b0, "t3_a2");
    smp(4'b0001, 4'b0001, 1'b0, "t3_accept");
    frm(4'b0000, "t3_f9");

    // priority: RESTART overwrites LEFT, LEFT cannot displace RESTART
    smp(4'b0010, 4'b0000, 1'b0, "t4_l1");
    smp(4'b0010, 4'b0000, 1'b0, "t4_l2");
    smp(4'b0010, 4'b0010, 1'b0, "t4_left");
    smp(4'b0100, 4'b0010, 1'b0, "t4_r1");
    smp(4'b0100, 4'b0010, 1'b0, "t4_r2");
    smp(4'b0100, 4'b0100, 1'b1, "t4_restart");
    smp(4'b0010, 4'b0100, 1'b0, "t4_m1");
    smp(4'b0010, 4'b0100, 1'b0, "t4_m2");
    smp(4'b0010, 4'b0100, 1'b1, "t4_left_lo");
    frm(4'b0000, "t4_fs");
    // RESTART cleared the cooldown, so JUMP is accepted; RIGHT is lower than JUMP
    smp(4'b0001, 4'b0000, 1'b0, "t4_j1");
    smp(4'b0001, 4'b0000, 1'b0, "t4_j2");
    smp(4'b0001, 4'b0001, 1'b0, "t4_jump_after_rst");
    smp(4'b1000, 4'b0001, 1'b0, "t4_g1");
    smp(4'b1000, 4'b0001, 1'b0, "t4_g2");
    smp(4'b1000, 4'b0001, 1'b1, "t4_right_lo");
    frm(4'b0000, "t4_fs2");

    // confirm coinciding with frame start while RIGHT is held
    smp(4'b1000, 4'b0000, 1'b0, "t5_g1");
    smp(4'b1000, 4'b0000, 1'b0, "t5_g2");
    smp(4'b1000, 4'b1000, 1'b0, "t5_right");
    smp(4'b0010, 4'b1000, 1'b0, "t5_l1");
    smp(4'b0010, 4'b1000, 1'b0, "t5_l2");
    repeat (3) cyc(1'b0, 4'b0100, 1'b0, 4'b1000, 1'b0, "t5_seen");
    cyc(1'b1, 4'b0010, 1'b1, 4'b0010, 1'b0, "t5_fs_cfm");
    cyc(1'b0, 4'b0100, 1'b0, 4'b0010, 1'b0, "t5_after");
    frm(4'b0000, "t5_fs2");
    frm(4'b0000, "t5_fs3");

    // async reset with a pending command and cooldown running
    smp(4'b1000, 4'b0000, 1'b0, "t6_g1");
    smp(4'b1000, 4'b0000, 1'b0, "t6_g2");
    smp(4'b1000, 4'b1000, 1'b0, "t6_pre");
    @(negedge vga_clk);
    sys_rst_n = 1'b0;
    #1;
    check("t6_rst_data", {4'b0, data_out}, 8'h00);
    check("t6_rst_drop", {7'b0, cmd_drop}, 8'h00);
    @(posedge vga_clk);
    #1;
    check("t6_rst_hold", {4'b0, data_out}, 8'h00);
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    hold = 4'b0000;

    for (int i = 0; i < 10; i++) smp(4'b0011, 4'b0000, 1'b0, "inv3");
    for (int i = 0; i < 10; i++) smp(4'b0000, 4'b0000, 1'b0, "inv0");
    smp(4'b0001, 4'b0000, 1'b0, "t6_j1");
    smp(4'b0001, 4'b0000, 1'b0, "t6_j2");
    smp(4'b0001, 4'b0001, 1'b0, "t6_jump_after_rst");
    frm(4'b0000, "end_fs");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
